// File: rtl/regfile_mp.sv
// Multi-port register file with post-reset hardware clear, write-port priority and collision flag.
// Define REGFILE_MP_BYPASS_EN to forward same-cycle write data to matching read lanes.
module regfile_mp #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  parameter int unsigned NRD   = 2,
  parameter int unsigned NWR   = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  output logic                 ready_o,
  input  logic [NRD*$clog2(NREGS)-1:0] rs_addr_i,
  output logic [NRD*XLEN-1:0]  rs_data_o,
  input  logic [NWR-1:0]       wr_en_i,
  input  logic [NWR*$clog2(NREGS)-1:0] wr_addr_i,
  input  logic [NWR*XLEN-1:0]  wr_data_i,
  output logic                 wr_conflict_o
);

  localparam int unsigned AW = $clog2(NREGS);

  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] RUN   = 1'b1;

  logic [0:0]    state, state_nxt;
  logic [AW-1:0] clr_idx, clr_idx_nxt;
  logic          ready_nxt;
  logic          conflict_nxt;
  logic          conflict_c;

  logic [XLEN-1:0] mem [NREGS];

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= CLEAR;
      clr_idx       <= AW'(1);
      ready_o       <= 1'b0;
      wr_conflict_o <= 1'b0;
    end else begin
      state         <= state_nxt;
      clr_idx       <= clr_idx_nxt;
      ready_o       <= ready_nxt;
      wr_conflict_o <= conflict_nxt;
    end
  end

  // Two or more enabled ports targeting the same nonzero address
  always_comb begin
    conflict_c = 1'b0;
    for (int i = 0; i < NWR; i++) begin
      for (int j = i + 1; j < NWR; j++) begin
        if (wr_en_i[i] && wr_en_i[j]
            && (wr_addr_i[i*AW +: AW] == wr_addr_i[j*AW +: AW])
            && (wr_addr_i[i*AW +: AW] != '0)) begin
          conflict_c = 1'b1;
        end
      end
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_nxt    = state;
    clr_idx_nxt  = clr_idx;
    ready_nxt    = ready_o;
    conflict_nxt = 1'b0;
    case (state)
      CLEAR: begin
        clr_idx_nxt = clr_idx + AW'(1);
        if (clr_idx == AW'(NREGS - 1)) begin
          state_nxt = RUN;
          ready_nxt = 1'b1;
        end
      end
      RUN: begin
        conflict_nxt = conflict_c;
      end
      default: begin
        state_nxt = CLEAR;
        ready_nxt = 1'b0;
      end
    endcase
  end

  // Storage: clear sweep, then prioritised writes (later ports override earlier ones)
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (state == CLEAR) begin
        mem[clr_idx] <= '0;
      end else begin
        for (int p = 0; p < NWR; p++) begin
          if (wr_en_i[p] && (wr_addr_i[p*AW +: AW] != '0)) begin
            mem[wr_addr_i[p*AW +: AW]] <= wr_data_i[p*XLEN +: XLEN];
          end
        end
      end
    end
  end

  // Combinational read lanes; zero while clearing and for register 0
  always_comb begin
    rs_data_o = '0;
    for (int k = 0; k < NRD; k++) begin
      if (ready_o && (rs_addr_i[k*AW +: AW] != '0)) begin
        rs_data_o[k*XLEN +: XLEN] = mem[rs_addr_i[k*AW +: AW]];
`ifdef REGFILE_MP_BYPASS_EN
        for (int p = 0; p < NWR; p++) begin
          if (wr_en_i[p] && (wr_addr_i[p*AW +: AW] == rs_addr_i[k*AW +: AW])) begin
            rs_data_o[k*XLEN +: XLEN] = wr_data_i[p*XLEN +: XLEN];
          end
        end
`endif
      end
    end
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port integer register file. It is the next-generation replacement for the single-write, two-read pipeline register file. It adds configurable width, depth and port counts, hardware clear after reset, write-port priority with collision flagging, and optional write-to-read forwarding. It sits in the decode stage: read ports serve operand fetch, and write ports are driven by writeback lanes.

Parameters:
XLEN, 32, data width of each register in bits
NREGS, 32, number of registers; power of two, at least 4; AW = $clog2(NREGS) is a derived localparam
NRD, 2, number of read ports, at least 1
NWR, 2, number of write ports, at least 1

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  synchronous, active-high reset
ready_o  output  1  high when the register file is cleared and accepting reads and writes
rs_addr_i  input  NRD*AW  read addresses; port k uses bits [k*AW +: AW]
rs_data_o  output  NRD*XLEN  read data; port k uses bits [k*XLEN +: XLEN]
wr_en_i  input  NWR  per-port write enable
wr_addr_i  input  NWR*AW  write addresses, packed as for reads
wr_data_i  input  NWR*XLEN  write data, packed as for reads
wr_conflict_o  output  1  registered pulse: two or more enabled ports wrote the same nonzero address in the previous cycle

Behaviour:
- One clock, clk_i. Reset is synchronous and active-high on rst_i. There is no asynchronous behaviour.
- Storage: NREGS x XLEN array. Register 0 is hardwired: writes to it are dropped, and reads of it return 0.
- FSM has two states, CLEAR and RUN, with a clear index clr_idx of width AW.
- Reset, on any edge where rst_i=1:
  - state <= CLEAR, clr_idx <= 1, ready_o <= 0, wr_conflict_o <= 0.
  - Array contents are untouched on this edge.
  - Holding rst_i high keeps clr_idx at 1, so no clear progress is made.
- CLEAR, on each edge with rst_i=0:
  - mem[clr_idx] <= 0, then clr_idx <= clr_idx + 1.
  - All wr_en_i inputs are ignored.
  - When clr_idx == NREGS-1, that entry is cleared, state <= RUN and ready_o <= 1.
  - Net effect: ready_o rises on the (NREGS-1)th edge after rst_i deasserts. For NREGS=32 this is edge 31.
- Reset mid-clear restarts the sequence from index 1.
- RUN writes:
  - For each port p with wr_en_i[p]=1 and a nonzero address: mem[addr_p] <= data_p on the edge.
  - If several enabled ports target the same address, the highest-index port wins. Lower-index ports to that address are discarded.
- RUN conflict flag:
  - wr_conflict_o <= 1 on the edge if two or more enabled ports hold an identical nonzero address. Otherwise it is 0.
  - The flag is a single-cycle pulse per conflicting cycle. Writes to address 0 never count as a conflict.
- Reads are combinational from the array with zero-cycle latency.
  - A read returns the pre-edge value, so without forwarding a write is visible from the next cycle.
  - While ready_o=0, every rs_data_o lane returns 0 regardless of address.
- rs_data_o has no reset of its own; it is all-zero whenever ready_o=0, which includes immediately after reset.
- Simultaneous clear and read: the read returns 0 because ready_o=0.

Optional Feature:
Macro REGFILE_MP_BYPASS_EN.
- Defined:
  - In RUN, a read lane whose address equals the address of a same-cycle enabled write returns wr_data_i combinationally.
  - The address must be nonzero.
  - If several ports match, the highest-index write port's data is returned.
  - Address 0 still reads 0.
- Undefined:
  - No forwarding; reads return stored contents only.
  - The forwarding logic must be entirely absent from the netlist.

Test Plan:
1. Reset and clear, NREGS=32, after the array is preloaded with non-zero values: hold rst_i=1 for 3 cycles, then release. Required: ready_o=0 for 30 edges, ready_o=1 after edge 31, and every register reads 0.
2. Single write, RUN: write port0 addr 5 = 0xDEADBEEF. Required: a same-cycle read of addr 5 returns the old value (0) without the macro, and 0xDEADBEEF from the next cycle on.
3. Collision: port0 and port1 both write addr 7, with 0x11 and 0x22 respectively. Required: the next cycle reads addr 7 = 0x22 and wr_conflict_o=1 for exactly one cycle.
4. x0: both ports write addr 0 with 0xFFFF_FFFF. Required: addr 0 reads 0 and wr_conflict_o stays 0.
5. Reset mid-clear: assert rst_i at edge 10 of CLEAR, then release. Required: a full 31-edge clear restarts, and writes issued during CLEAR are dropped (addr 3 still reads 0).
6. With REGFILE_MP_BYPASS_EN: port1 writes addr 9 = 0xCAFE while rs0 and rs1 both read addr 9. Required: both lanes show 0xCAFE in the same cycle.
